// File: rtl/chess_move_controller.sv
// Chess move controller: debounced key/switch input, cursor, select/move FSM.
// Owns the 64-square board and drives the packed Layout bus for the renderer.
module chess_move_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 19
) (
  input  logic         clock,
  input  logic         resetApp,
  input  logic         KeyLeft,
  input  logic         KeyUp,
  input  logic         KeyDown,
  input  logic         KeyRight,
  input  logic         LockSwitch,
  output logic [511:0] Layout,
  output logic         turn,
  output logic         moveDone
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HELD = 1'b1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  // bit order: 0 left, 1 right, 2 up, 3 down, 4 lock
  localparam logic [4:0] RELEASED = 5'b01111;

  logic [4:0]           raw;
  logic [4:0]           s1_q, s2_q, acc_q, evt_q;
  logic [CNT_WIDTH-1:0] cnt_q [5];
  logic [1:0]           init_q;

  logic [7:0]  board_q [64];
  logic [7:0]  board_d [64];
  logic [5:0]  cursor_q, cursor_d, src_q, src_d, nxt;
  logic [0:0]  state_q, state_d;
  logic        turn_q, turn_d, done_q, done_d;
  logic [7:0]  cur;
  logic        own;
  logic        held;

  function automatic logic [7:0] start_sq(input int s);
    logic [2:0] p;
    unique case (s % 8)
      0, 7:    p = 3'd5;
      1, 6:    p = 3'd4;
      2, 5:    p = 3'd3;
      3:       p = 3'd2;
      default: p = 3'd1;
    endcase
    unique case (s / 8)
      0:       return {5'b00000, p};
      1:       return 8'h06;
      6:       return 8'h0E;
      7:       return {5'b00001, p};
      default: return 8'h00;
    endcase
  endfunction

  assign raw = {LockSwitch, KeyDown, KeyUp, KeyRight, KeyLeft};

  // Synchronise, debounce and turn accepted level changes into event pulses.
  // The lock switch has no released level, so for the first cycles after
  // reset its accepted level simply tracks the synchronised input.
  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      s1_q   <= RELEASED;
      s2_q   <= RELEASED;
      acc_q  <= RELEASED;
      evt_q  <= '0;
      init_q <= 2'd3;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
    end else begin
      s1_q  <= raw;
      s2_q  <= s1_q;
      evt_q <= '0;
      for (int i = 0; i < 5; i++) begin
        if (s2_q[i] == acc_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          cnt_q[i] <= '0;
          acc_q[i] <= s2_q[i];
          evt_q[i] <= (i == 4) ? 1'b1 : acc_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
      if (init_q != 2'd0) begin
        init_q   <= init_q - 2'd1;
        acc_q[4] <= s2_q[4];
        cnt_q[4] <= '0;
        evt_q[4] <= 1'b0;
      end
    end
  end

  assign cur  = board_q[cursor_q];
  assign own  = (cur[2:0] != 3'd0) && (cur[3] == turn_q);
  assign held = (state_q == HELD);

  // Target square of a cursor move, wrapping within row or column.
  always_comb begin
    nxt = cursor_q;
    if (evt_q[0])      nxt = {cursor_q[5:3], cursor_q[2:0] - 3'd1};
    else if (evt_q[1]) nxt = {cursor_q[5:3], cursor_q[2:0] + 3'd1};
    else if (evt_q[2]) nxt = {cursor_q[5:3] - 3'd1, cursor_q[2:0]};
    else if (evt_q[3]) nxt = {cursor_q[5:3] + 3'd1, cursor_q[2:0]};
  end

  // Select/move FSM and cursor marks; lock wins over all direction keys.
  always_comb begin
    board_d  = board_q;
    cursor_d = cursor_q;
    src_d    = src_q;
    state_d  = state_q;
    turn_d   = turn_q;
    done_d   = 1'b0;
    if (evt_q[4]) begin
      if (!held) begin
        if (own) begin
          board_d[cursor_q][5:4] = 2'd2;
          src_d   = cursor_q;
          state_d = HELD;
        end
      end else if (cursor_q == src_q) begin
        board_d[cursor_q][5:4] = 2'd1;
        state_d = IDLE;
      end else if (!own) begin
        board_d[cursor_q] = {4'b0011, board_q[src_q][3:0]};
        board_d[src_q]    = 8'h00;
        turn_d  = ~turn_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end else if (|evt_q[3:0]) begin
      if (!(held && cursor_q == src_q)) board_d[cursor_q][5:4] = 2'd0;
      if (!(held && nxt == src_q))      board_d[nxt][5:4]      = 2'd1;
      cursor_d = nxt;
    end
  end

  // Board and FSM registers; reset restores the start position at once.
  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      for (int s = 0; s < 64; s++) board_q[s] <= start_sq(s);
      board_q[52][5:4] <= 2'd1;
      cursor_q <= 6'd52;
      src_q    <= 6'd52;
      state_q  <= IDLE;
      turn_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      board_q  <= board_d;
      cursor_q <= cursor_d;
      src_q    <= src_d;
      state_q  <= state_d;
      turn_q   <= turn_d;
      done_q   <= done_d;
    end
  end

  // Pack the board onto the renderer bus.
  always_comb begin
    Layout = '0;
    for (int s = 0; s < 64; s++) Layout[8*s +: 8] = board_q[s];
  end

  assign turn     = turn_q;
  assign moveDone = done_q;

endmodule

// File: tb/tb_chess_move_controller.sv
// Bench for chess_move_controller with short debounce.
// Committed moves are scoreboarded and checked when moveDone fires.
module tb_chess_move_controller;

  logic         clock = 1'b0;
  logic         resetApp = 1'b1;
  logic         KeyLeft = 1'b1, KeyUp = 1'b1, KeyDown = 1'b1, KeyRight = 1'b1;
  logic         LockSwitch = 1'b0;
  logic [511:0] Layout;
  logic         turn, moveDone;

  typedef struct {
    int         sq;
    logic [7:0] b;
    logic       t;
  } mv_t;

  mv_t exp_q[$];
  int  n_chk = 0;
  int  n_pass = 0;
  int  n_done = 0;

  chess_move_controller #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(3)) dut (
    .clock(clock), .resetApp(resetApp),
    .KeyLeft(KeyLeft), .KeyUp(KeyUp), .KeyDown(KeyDown), .KeyRight(KeyRight),
    .LockSwitch(LockSwitch), .Layout(Layout), .turn(turn), .moveDone(moveDone)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] sq(input int s);
    return Layout[8*s +: 8];
  endfunction

  function automatic logic [511:0] start_pos();
    logic [511:0] l;
    int back [8];
    back = '{5, 4, 3, 2, 1, 3, 4, 5};
    l = '0;
    for (int c = 0; c < 8; c++) begin
      l[8*c +: 8]      = 8'(back[c]);
      l[8*(8+c) +: 8]  = 8'h06;
      l[8*(48+c) +: 8] = 8'h0E;
      l[8*(56+c) +: 8] = 8'(back[c] + 8);
    end
    l[8*52 +: 8] = 8'h1E;
    return l;
  endfunction

  // Scoreboard: each moveDone pulse pops one expected move.
  always @(negedge clock) begin
    if (!resetApp && moveDone) begin
      n_done++;
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL move_unexpected: moveDone with no move queued");
      end else begin
        mv_t m;
        m = exp_q.pop_front();
        if (sq(m.sq) !== m.b || turn !== m.t)
          $display("FAIL move_commit: sq%0d=%h turn=%b want %h %b",
                   m.sq, sq(m.sq), turn, m.b, m.t);
        else n_pass++;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press(input int k);
    case (k)
      0: KeyLeft = 1'b0;
      1: KeyRight = 1'b0;
      2: KeyUp = 1'b0;
      default: KeyDown = 1'b0;
    endcase
    cycles(10);
    {KeyLeft, KeyRight, KeyUp, KeyDown} = 4'hF;
    cycles(10);
  endtask

  task automatic flip_lock();
    LockSwitch = ~LockSwitch;
    cycles(12);
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetApp = 1'b1;
    cycles(2);
    resetApp = 1'b0;
    cycles(6);
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if (Layout !== start_pos()) $display("FAIL reset_layout: %h", Layout);
    else n_pass++;
    n_chk++;
    if (sq(52) !== 8'h1E) $display("FAIL reset_sq52: %h want 1e", sq(52));
    else n_pass++;
    n_chk++;
    if (sq(0) !== 8'h05) $display("FAIL reset_sq0: %h want 05", sq(0));
    else n_pass++;
    n_chk++;
    if (turn !== 1'b1 || moveDone !== 1'b0)
      $display("FAIL reset_turn: turn=%b done=%b want 1 0", turn, moveDone);
    else n_pass++;
  endtask

  task automatic test_debounce();
    do_reset();
    KeyUp = 1'b0;
    cycles(2);
    KeyUp = 1'b1;
    cycles(8);
    n_chk++;
    if (sq(52) !== 8'h1E) $display("FAIL bounce_ignored: sq52=%h want 1e", sq(52));
    else n_pass++;
    press(2);
    n_chk++;
    if (sq(44) !== 8'h10 || sq(52) !== 8'h0E || sq(36) !== 8'h00)
      $display("FAIL debounce_up: 44=%h 52=%h 36=%h want 10 0e 00",
               sq(44), sq(52), sq(36));
    else n_pass++;
  endtask

  task automatic test_move();
    int d0;
    do_reset();
    flip_lock();
    n_chk++;
    if (sq(52) !== 8'h2E) $display("FAIL select: sq52=%h want 2e", sq(52));
    else n_pass++;
    press(2);
    press(2);
    n_chk++;
    if (sq(36) !== 8'h10 || sq(44) !== 8'h00 || sq(52) !== 8'h2E)
      $display("FAIL held_cursor: 36=%h 44=%h 52=%h want 10 00 2e",
               sq(36), sq(44), sq(52));
    else n_pass++;
    d0 = n_done;
    exp_q.push_back('{sq: 36, b: 8'h3E, t: 1'b0});
    flip_lock();
    n_chk++;
    if (sq(36) !== 8'h3E || sq(52) !== 8'h00 || turn !== 1'b0)
      $display("FAIL commit: 36=%h 52=%h turn=%b want 3e 00 0",
               sq(36), sq(52), turn);
    else n_pass++;
    n_chk++;
    if (n_done - d0 !== 1) $display("FAIL done_pulses: %0d want 1", n_done - d0);
    else n_pass++;
    press(3);
    n_chk++;
    if (sq(36) !== 8'h0E || sq(44) !== 8'h10)
      $display("FAIL post_clear: 36=%h 44=%h want 0e 10", sq(36), sq(44));
    else n_pass++;
  endtask

  task automatic test_wrong_colour();
    logic [511:0] snap;
    do_reset();
    repeat (5) press(2);
    snap = Layout;
    n_chk++;
    if (sq(12) !== 8'h16) $display("FAIL cursor_12: sq12=%h want 16", sq(12));
    else n_pass++;
    flip_lock();
    n_chk++;
    if (Layout !== snap || turn !== 1'b1)
      $display("FAIL wrong_colour: sq12=%h turn=%b want 16 1", sq(12), turn);
    else n_pass++;
    repeat (5) press(0);
    n_chk++;
    if (sq(15) !== 8'h16 || sq(8) !== 8'h06)
      $display("FAIL wrap_left: 15=%h 8=%h want 16 06", sq(15), sq(8));
    else n_pass++;
  endtask

  task automatic test_unselect();
    do_reset();
    flip_lock();
    flip_lock();
    n_chk++;
    if (sq(52) !== 8'h1E || turn !== 1'b1)
      $display("FAIL unselect: sq52=%h turn=%b want 1e 1", sq(52), turn);
    else n_pass++;
    flip_lock();
    press(1);
    flip_lock();
    n_chk++;
    if (sq(52) !== 8'h2E || sq(53) !== 8'h1E || turn !== 1'b1)
      $display("FAIL own_ignored: 52=%h 53=%h turn=%b want 2e 1e 1",
               sq(52), sq(53), turn);
    else n_pass++;
    press(0);
    n_chk++;
    if (sq(52) !== 8'h2E || sq(53) !== 8'h0E)
      $display("FAIL back_to_src: 52=%h 53=%h want 2e 0e", sq(52), sq(53));
    else n_pass++;
    flip_lock();
    n_chk++;
    if (sq(52) !== 8'h1E) $display("FAIL unselect2: sq52=%h want 1e", sq(52));
    else n_pass++;
  endtask

  task automatic test_priority_and_reset();
    do_reset();
    KeyLeft = 1'b0;
    LockSwitch = ~LockSwitch;
    cycles(12);
    n_chk++;
    if (sq(52) !== 8'h2E || sq(51) !== 8'h0E)
      $display("FAIL priority: 52=%h 51=%h want 2e 0e", sq(52), sq(51));
    else n_pass++;
    KeyLeft = 1'b1;
    cycles(10);
    @(negedge clock);
    #2 resetApp = 1'b1;
    #1;
    n_chk++;
    if (Layout !== start_pos() || turn !== 1'b1 || moveDone !== 1'b0)
      $display("FAIL async_reset: sq52=%h turn=%b", sq(52), turn);
    else n_pass++;
    @(negedge clock);
    resetApp = 1'b0;
    cycles(20);
    n_chk++;
    if (sq(52) !== 8'h1E) $display("FAIL no_spurious_lock: sq52=%h want 1e", sq(52));
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_move();
    test_wrong_colour();
    test_unselect();
    test_priority_and_reset();
    n_chk++;
    if (exp_q.size() != 0) $display("FAIL sb_leftover: %0d moves pending", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
